// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/button inputs, entry display and operand memory write port.
interface operand_loader_if;
    logic [3:0]  nibble;
    logic [2:0]  addr;
    logic        push;
    logic        commit;
    logic        clear;
    logic [31:0] entry;
    logic [3:0]  count;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        full;
    modport master (
        input  nibble, addr, push, commit, clear,
        output entry, count, wr_en, wr_addr, wr_data, busy, full
    );
    modport slave (
        output nibble, addr, push, commit, clear,
        input  entry, count, wr_en, wr_addr, wr_data, busy, full
    );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: debounced hex-digit entry committed to operand memory.
// Define OPERAND_LOADER_SIGN_EXT_EN to sign-extend partial entries on write.
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W = 16
) (
    input logic clk_i,
    input logic rst_ni,
    operand_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE, ENTRY, WRITE} state_t;
    state_t state;
    logic [2:0] s1, s2, lvl, lvl_q, p;
    logic [CNT_W-1:0] cnt [3];
    logic [31:0] data_ext;
`ifdef OPERAND_LOADER_SIGN_EXT_EN
    logic [5:0] sh;
    assign sh = 6'd32 - {bus.count, 2'b00};
    assign data_ext = $signed(bus.entry << sh) >>> sh;
`else
    assign data_ext = bus.entry;
`endif
    assign bus.full = bus.count == 4'd8;
    // bit order {clear, commit, push}; p is the one-cycle press pulse per button
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1 <= '0;
            s2 <= '0;
            lvl <= '0;
            lvl_q <= '0;
            p <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= {bus.clear, bus.commit, bus.push};
            s2 <= s1;
            lvl_q <= lvl;
            p <= lvl & ~lvl_q;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == lvl[i]) cnt[i] <= '0;
                else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            bus.entry <= '0;
            bus.count <= '0;
            bus.wr_en <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (p == 3'b001) begin
                    bus.entry <= {bus.entry[27:0], bus.nibble};
                    bus.count <= bus.count + 4'd1;
                    state <= ENTRY;
                end
                ENTRY: if (p[2]) begin
                    bus.entry <= '0;
                    bus.count <= '0;
                    state <= IDLE;
                end else if (p[1]) begin
                    bus.wr_en <= 1'b1;
                    bus.busy <= 1'b1;
                    bus.wr_addr <= bus.addr;
                    bus.wr_data <= data_ext;
                    state <= WRITE;
                end else if (p[0] && !bus.full) begin
                    bus.entry <= {bus.entry[27:0], bus.nibble};
                    bus.count <= bus.count + 4'd1;
                end
                WRITE: begin
                    bus.wr_en <= 1'b0;
                    bus.busy <= 1'b0;
                    bus.entry <= '0;
                    bus.count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed presses checked every cycle against a digit-level model.
module tb_operand_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int wr_seen = 0;
    logic [31:0] last_data = '0;
    logic [2:0] last_addr = '0;
    logic [31:0] m_entry = '0;
    int m_count = 0;
    logic m_wr = 1'b0;
    logic [2:0] m_addr = '0;
    logic [31:0] m_data = '0;

    operand_loader_if bus();
    operand_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ext(input logic [31:0] e, input int n);
`ifdef OPERAND_LOADER_SIGN_EXT_EN
        if (n > 0 && n < 8 && e[4*n-1]) return e | (32'hFFFF_FFFF << (4 * n));
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (run) begin
        vectors++;
        if (bus.entry !== m_entry || bus.count !== 4'(m_count) || bus.full !== (m_count == 8) ||
            bus.wr_en !== m_wr || bus.busy !== m_wr ||
            (m_wr && (bus.wr_addr !== m_addr || bus.wr_data !== m_data))) begin
            miscompares++;
            $display("FAIL cycle t=%0t entry %h/%h count %0d/%0d wr_en %b/%b addr %0d/%0d data %h/%h",
                     $time, bus.entry, m_entry, bus.count, m_count, bus.wr_en, m_wr,
                     bus.wr_addr, m_addr, bus.wr_data, m_data);
        end
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            last_data = bus.wr_data;
            last_addr = bus.wr_addr;
        end
    end

    // raise buttons {clear,commit,push}; the press takes effect on the 8th edge
    task automatic press(input logic [2:0] b, input logic [3:0] nib);
        @(posedge clk);
        #1 {bus.clear, bus.commit, bus.push} = b;
        bus.nibble = nib;
        repeat (8) @(posedge clk);
        if (b[2]) begin
            m_entry = '0;
            m_count = 0;
        end else if (b[1]) begin
            if (m_count > 0) begin
                m_wr = 1'b1;
                m_addr = bus.addr;
                m_data = ext(m_entry, m_count);
                #1 bus.addr = ~bus.addr;
                @(posedge clk);
                m_wr = 1'b0;
                m_entry = '0;
                m_count = 0;
            end
        end else if (b[0] && m_count < 8) begin
            m_entry = (m_entry << 4) | 32'(nib);
            m_count++;
        end
        #1 {bus.clear, bus.commit, bus.push} = 3'b000;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        int w;
        logic [3:0] digs [9];
        bus.nibble = '0;
        bus.addr = '0;
        {bus.clear, bus.commit, bus.push} = 3'b000;
        @(posedge clk);
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("rst_entry", bus.entry, 32'h0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("idle_no_write", wr_seen, 0);

        bus.nibble = 4'h7;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 bus.push = (i % 4) < 2;
        end
        @(posedge clk);
        #1 bus.push = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("bounce_before", 32'(bus.count), 32'd0);
        @(posedge clk);
        m_entry = 32'h7;
        m_count = 1;
        @(negedge clk);
        chk("bounce_after", 32'(bus.count), 32'd1);
        repeat (20) @(posedge clk);
        chk("held_one_digit", 32'(bus.count), 32'd1);
        #1 bus.push = 1'b0;
        repeat (12) @(posedge clk);
        press(3'b100, 4'h0);
        @(negedge clk);
        chk("clear_entry", bus.entry, 32'h0);

        for (int i = 1; i <= 4; i++) press(3'b001, 4'(i));
        @(negedge clk);
        chk("entry_1234", bus.entry, 32'h0000_1234);
        bus.addr = 3'd5;
        w = wr_seen;
        press(3'b010, 4'h0);
        @(negedge clk);
        chk("wr_data_1234", last_data, 32'h0000_1234);
        chk("wr_addr_5", 32'(last_addr), 32'd5);
        chk("one_write", wr_seen - w, 1);
        chk("entry_cleared", bus.entry, 32'h0);

        digs = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
        for (int i = 0; i < 9; i++) press(3'b001, digs[i]);
        @(negedge clk);
        chk("entry_full", bus.entry, 32'hABCD_EF01);
        chk("full_flag", 32'(bus.full), 32'd1);
        bus.addr = 3'd2;
        press(3'b010, 4'h0);
        chk("wr_data_full", last_data, 32'hABCD_EF01);
        chk("wr_addr_2", 32'(last_addr), 32'd2);

        for (int i = 1; i <= 3; i++) press(3'b001, 4'(i));
        w = wr_seen;
        press(3'b110, 4'h0);
        @(negedge clk);
        chk("prio_no_write", wr_seen - w, 0);
        chk("prio_entry", bus.entry, 32'h0);
        press(3'b010, 4'h0);
        chk("empty_commit", wr_seen - w, 0);

        press(3'b001, 4'hF);
        press(3'b001, 4'h0);
        press(3'b001, 4'h1);
        @(negedge clk);
        chk("entry_f01", bus.entry, 32'h0000_0F01);
        bus.addr = 3'd3;
        press(3'b010, 4'h0);
`ifdef OPERAND_LOADER_SIGN_EXT_EN
        chk("wr_data_f01", last_data, 32'hFFFF_FF01);
`else
        chk("wr_data_f01", last_data, 32'h0000_0F01);
`endif
        chk("wr_addr_3", 32'(last_addr), 32'd3);

        @(negedge clk);
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
